// File: rtl/etapa_wb_banco.sv
// etapa_wb_banco
// Write-back stage and integer register bank at the consuming end of MEM/WB.
// Selects ALU result or load data, commits it to the addressed register and
// serves two combinational read ports to decode. Register 0 reads as zero and
// ignores writes. A registered trace reports each effective write one cycle
// later.
//
// Build option: define ETAPA_WB_BYPASS_EN to make a same-cycle write visible
// on a read port addressing the destination (write-before-read).
//
// Ports:
//   clk, reinicio (sync, active-high)
//   escribir_reg_entrada, mem_a_reg_entrada, resultado_alu_entrada,
//   dato_mem_entrada, registro_destino_entrada   -- MEM/WB write request
//   dir_lectura_a/b  -> dato_lectura_a/b         -- combinational reads
//   escritura_valida_salida, registro_escrito_salida,
//   dato_escrito_salida                          -- commit trace
module etapa_wb_banco #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5
) (
  input  logic                  clk,
  input  logic                  reinicio,
  input  logic                  escribir_reg_entrada,
  input  logic                  mem_a_reg_entrada,
  input  logic [ANCHO_DATO-1:0] resultado_alu_entrada,
  input  logic [ANCHO_DATO-1:0] dato_mem_entrada,
  input  logic [ANCHO_DIR-1:0]  registro_destino_entrada,
  input  logic [ANCHO_DIR-1:0]  dir_lectura_a,
  input  logic [ANCHO_DIR-1:0]  dir_lectura_b,
  output logic [ANCHO_DATO-1:0] dato_lectura_a,
  output logic [ANCHO_DATO-1:0] dato_lectura_b,
  output logic                  escritura_valida_salida,
  output logic [ANCHO_DIR-1:0]  registro_escrito_salida,
  output logic [ANCHO_DATO-1:0] dato_escrito_salida
);

  localparam int NUM_REG = 2**ANCHO_DIR;

  logic [ANCHO_DATO-1:0] banco [NUM_REG];
  logic [ANCHO_DATO-1:0] dato_wb;
  logic                  escritura_efectiva;

  always_comb begin
    dato_wb            = mem_a_reg_entrada ? dato_mem_entrada : resultado_alu_entrada;
    escritura_efectiva = escribir_reg_entrada && (registro_destino_entrada != '0) && !reinicio;
  end

  // Entry 0 is cleared on reset and never written, so it stays zero.
  always_ff @(posedge clk) begin
    if (reinicio) begin
      banco <= '{default: '0};
    end else if (escritura_efectiva) begin
      banco[registro_destino_entrada] <= dato_wb;
    end
  end

  always_ff @(posedge clk) begin
    if (reinicio) begin
      escritura_valida_salida <= 1'b0;
      registro_escrito_salida <= '0;
      dato_escrito_salida     <= '0;
    end else begin
      escritura_valida_salida <= escritura_efectiva;
      if (escritura_efectiva) begin
        registro_escrito_salida <= registro_destino_entrada;
        dato_escrito_salida     <= dato_wb;
      end
    end
  end

  // escritura_efectiva already excludes address 0 and reset, so the bypass
  // compare needs no extra qualification.
  always_comb begin
    dato_lectura_a = banco[dir_lectura_a];
`ifdef ETAPA_WB_BYPASS_EN
    if (escritura_efectiva && (dir_lectura_a == registro_destino_entrada)) begin
      dato_lectura_a = dato_wb;
    end
`endif
    if (reinicio || (dir_lectura_a == '0)) begin
      dato_lectura_a = '0;
    end
  end

  always_comb begin
    dato_lectura_b = banco[dir_lectura_b];
`ifdef ETAPA_WB_BYPASS_EN
    if (escritura_efectiva && (dir_lectura_b == registro_destino_entrada)) begin
      dato_lectura_b = dato_wb;
    end
`endif
    if (reinicio || (dir_lectura_b == '0)) begin
      dato_lectura_b = '0;
    end
  end

endmodule

// File: tb/tb_etapa_wb_banco.sv
module tb_etapa_wb_banco;

  logic        clk = 1'b0;
  logic        reinicio = 1'b1;
  logic        escribir_reg_entrada = 1'b0;
  logic        mem_a_reg_entrada = 1'b0;
  logic [31:0] resultado_alu_entrada = '0;
  logic [31:0] dato_mem_entrada = '0;
  logic [4:0]  registro_destino_entrada = '0;
  logic [4:0]  dir_lectura_a = '0;
  logic [4:0]  dir_lectura_b = '0;
  logic [31:0] dato_lectura_a, dato_lectura_b;
  logic        escritura_valida_salida;
  logic [4:0]  registro_escrito_salida;
  logic [31:0] dato_escrito_salida;

  etapa_wb_banco #(.ANCHO_DATO(32), .ANCHO_DIR(5)) dut (
    .clk(clk),
    .reinicio(reinicio),
    .escribir_reg_entrada(escribir_reg_entrada),
    .mem_a_reg_entrada(mem_a_reg_entrada),
    .resultado_alu_entrada(resultado_alu_entrada),
    .dato_mem_entrada(dato_mem_entrada),
    .registro_destino_entrada(registro_destino_entrada),
    .dir_lectura_a(dir_lectura_a),
    .dir_lectura_b(dir_lectura_b),
    .dato_lectura_a(dato_lectura_a),
    .dato_lectura_b(dato_lectura_b),
    .escritura_valida_salida(escritura_valida_salida),
    .registro_escrito_salida(registro_escrito_salida),
    .dato_escrito_salida(dato_escrito_salida)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: architectural register file as a plain array.
  logic [31:0] regs [32];
  // Expected trace entries {register, value}, one per committed write.
  logic [36:0] trace_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic rst, input logic eff,
                                           input logic [4:0] dest, input logic [31:0] wb,
                                           input logic [4:0] addr);
    if (rst || addr == 5'd0) return 32'd0;
`ifdef ETAPA_WB_BYPASS_EN
    if (eff && addr == dest) return wb;
`endif
    return regs[addr];
  endfunction

  // One cycle: present inputs, check reads in that cycle, update the model.
  task automatic step(input logic rst, input logic wr, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic [4:0] dest, input logic [4:0] ra, input logic [4:0] rb);
    logic        eff;
    logic [31:0] wb;
    @(posedge clk);
    #2;
    reinicio = rst; escribir_reg_entrada = wr; mem_a_reg_entrada = m2r;
    resultado_alu_entrada = alu; dato_mem_entrada = mem;
    registro_destino_entrada = dest; dir_lectura_a = ra; dir_lectura_b = rb;
    wb  = m2r ? mem : alu;
    eff = wr && (dest != 5'd0) && !rst;
    if (eff) trace_q.push_back({dest, wb});
    #5;
    chk("read_a", dato_lectura_a, ref_read(rst, eff, dest, wb, ra));
    chk("read_b", dato_lectura_b, ref_read(rst, eff, dest, wb, rb));
    if (rst) foreach (regs[i]) regs[i] = 32'd0;
    else if (eff) regs[dest] = wb;
  endtask

  // Monitor: consumes trace pulses and compares against the queue.
  logic [4:0]  last_reg = '0;
  logic [31:0] last_dat = '0;
  initial begin
    logic        rst_at_edge;
    logic [36:0] e;
    forever begin
      @(posedge clk);
      rst_at_edge = reinicio;
      #1;
      if (rst_at_edge) begin
        chk("trace_valid_rst", {31'd0, escritura_valida_salida}, 32'd0);
        chk("trace_reg_rst", {27'd0, registro_escrito_salida}, 32'd0);
        chk("trace_dat_rst", dato_escrito_salida, 32'd0);
        last_reg = '0; last_dat = '0;
      end else if (escritura_valida_salida === 1'b1) begin
        if (trace_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL trace_spurious actual=valid expected=idle reg=%0d time=%0t",
                   registro_escrito_salida, $time);
        end else begin
          e = trace_q.pop_front();
          chk("trace_reg", {27'd0, registro_escrito_salida}, {27'd0, e[36:32]});
          chk("trace_dat", dato_escrito_salida, e[31:0]);
          last_reg = e[36:32]; last_dat = e[31:0];
        end
      end else begin
        chk("trace_valid", {31'd0, escritura_valida_salida}, {31'd0, (trace_q.size() != 0)});
        chk("trace_reg_hold", {27'd0, registro_escrito_salida}, {27'd0, last_reg});
        chk("trace_dat_hold", dato_escrito_salida, last_dat);
        if (trace_q.size() != 0) void'(trace_q.pop_front());
      end
    end
  end

  initial begin
    foreach (regs[i]) regs[i] = 32'd0;
    // reset, then r5=0x1234, then reset with a write to r6 presented
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h1234, 0, 5, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 5);
    step(1, 1, 0, 32'hAAAA, 0, 6, 5, 6);
    step(0, 0, 0, 0, 0, 0, 5, 6);
    // ALU and load write-back
    step(0, 1, 0, 32'hDEADBEEF, 0, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 7, 7);
    step(0, 1, 1, 32'hFFFFFFFF, 32'h42, 3, 7, 3);
    step(0, 0, 0, 0, 0, 0, 3, 0);
    // register 0 ignores writes
    step(0, 1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    // same-cycle read of the written register
    step(0, 1, 0, 32'h11, 0, 9, 0, 0);
    step(0, 1, 0, 32'h22, 0, 9, 9, 9);
    step(0, 0, 0, 0, 0, 0, 9, 9);
    // back-to-back writes
    step(0, 1, 0, 1, 0, 1, 1, 2);
    step(0, 1, 1, 0, 2, 2, 1, 2);
    step(0, 1, 0, 3, 0, 1, 1, 2);
    step(0, 0, 0, 0, 0, 0, 1, 2);
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] d, a, b;
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           $urandom, $urandom, d, a, b);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    chk("trace_queue_drained", trace_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
